// File: rtl/ghost_mover.sv
// ghost_mover: one ghost sprite for the Pacman playfield.
// Holds the ghost position, moves it per movement tick with toroidal wrap,
// runs the HOME / ACTIVE / FRIGHT / EATEN behaviour machine, detects contact
// with Pacman geometrically and draws the ghost box against the raster.
// Build option: define GHOST_FRIGHT_EN for the frightened/eaten behaviour.
// Without it the ghost only has HOME and ACTIVE and powerPellet is ignored.
module ghost_mover #(
  parameter int FIELD_W      = 380,
  parameter int FIELD_H      = 432,
  parameter int SPRITE_W     = 21,
  parameter int PAC_W        = 21,
  parameter int OFFSET_H     = 274,
  parameter int OFFSET_V     = 58,
  parameter int SPEED_W      = 5,
  parameter int HOME_TICKS   = 60,
  parameter int FRIGHT_TICKS = 600
) (
  input  logic               move_clk,
  input  logic               reset,
  input  logic [9:0]         xIni,
  input  logic [9:0]         yIni,
  input  logic [1:0]         direction,
  input  logic [SPEED_W-1:0] speed,
  input  logic [9:0]         pacX,
  input  logic [9:0]         pacY,
  input  logic               powerPellet,
  input  logic [9:0]         hCount,
  input  logic [9:0]         vCount,
  output logic               ghostFill,
  output logic               touchPac,
  output logic               ghostEaten,
  output logic               frightened,
  output logic [1:0]         state
);

  typedef enum logic [1:0] {
    HOME   = 2'b00,
    ACTIVE = 2'b01,
    FRIGHT = 2'b10,
    EATEN  = 2'b11
  } ghostState_t;

  localparam int HG = (SPRITE_W - 1) / 2;
  localparam int HP = (PAC_W - 1) / 2;
  localparam logic [10:0] CONTACT = 11'(HG + HP);
  localparam logic [10:0] HALF_BOX = 11'(HG);
  localparam logic signed [11:0] FIELD_X = 12'(FIELD_W);
  localparam logic signed [11:0] FIELD_Y = 12'(FIELD_H);
  localparam int HOME_CNT_W = (HOME_TICKS > 1) ? $clog2(HOME_TICKS) : 1;
  localparam logic [HOME_CNT_W-1:0] HOME_LAST = HOME_CNT_W'(HOME_TICKS - 1);

  ghostState_t stateCur, stateNext;
  logic [9:0] ghostX, ghostY, xNext, yNext;
  logic [HOME_CNT_W-1:0] homeCnt, homeCntNext;
  logic doMove;
  logic [SPEED_W-1:0] step;
  logic [10:0] absDx, absDy;
  logic overlap;
  logic [10:0] boxLeft, boxTop, hCount11, vCount11;

`ifdef GHOST_FRIGHT_EN
  localparam int FRIGHT_CNT_W = $clog2(FRIGHT_TICKS + 1);
  localparam logic [FRIGHT_CNT_W-1:0] FRIGHT_LOAD = FRIGHT_CNT_W'(FRIGHT_TICKS);
  logic [FRIGHT_CNT_W-1:0] frightCnt, frightCntNext;
  logic eatenNext;
`endif

  // One step along an axis in 12-bit signed arithmetic, folded back into [0, size-1].
  function automatic logic [9:0] wrapMove(input logic [9:0] pos,
                                          input logic [SPEED_W-1:0] delta,
                                          input logic decrement,
                                          input logic signed [11:0] size);
    logic signed [11:0] n;
    if (decrement) n = $signed({2'b00, pos}) - $signed(12'(delta));
    else           n = $signed({2'b00, pos}) + $signed(12'(delta));
    if (n < 0)          n = n + size;
    else if (n >= size) n = n - size;
    return n[9:0];
  endfunction

  // Box-to-box contact on the current registers; deliberately ignores wrap.
  assign absDx = (ghostX >= pacX) ? {1'b0, ghostX - pacX} : {1'b0, pacX - ghostX};
  assign absDy = (ghostY >= pacY) ? {1'b0, ghostY - pacY} : {1'b0, pacY - ghostY};
  assign overlap = (absDx <= CONTACT) && (absDy <= CONTACT);

  // Raster box test; the lower bound is rearranged so nothing is subtracted.
  assign boxLeft  = {1'b0, ghostX} + 11'(OFFSET_H);
  assign boxTop   = {1'b0, ghostY} + 11'(OFFSET_V);
  assign hCount11 = {1'b0, hCount};
  assign vCount11 = {1'b0, vCount};
  assign ghostFill = (hCount11 + HALF_BOX >= boxLeft) && (hCount11 <= boxLeft + HALF_BOX) &&
                     (vCount11 + HALF_BOX >= boxTop)  && (vCount11 <= boxTop + HALF_BOX);

  assign touchPac = (stateCur == ACTIVE) && overlap;
  assign state    = stateCur;

  // Next-state, next-position and counter updates for the behaviour machine.
  always_comb begin
    // NOTE: every signal this block writes gets a default first, so no path can infer a latch.
    stateNext   = stateCur;
    xNext       = ghostX;
    yNext       = ghostY;
    homeCntNext = homeCnt;
    doMove      = 1'b0;
    step        = '0;
`ifdef GHOST_FRIGHT_EN
    frightCntNext = frightCnt;
    eatenNext     = 1'b0;
`endif
    case (stateCur)
      HOME: begin
        xNext = xIni;
        yNext = yIni;
        if (homeCnt == HOME_LAST) begin
          stateNext   = ACTIVE;
          homeCntNext = '0;
        end else begin
          homeCntNext = homeCnt + HOME_CNT_W'(1);
        end
      end
      ACTIVE: begin
        doMove = 1'b1;
        step   = speed;
`ifdef GHOST_FRIGHT_EN
        if (powerPellet) begin
          stateNext     = FRIGHT;
          frightCntNext = FRIGHT_LOAD;
        end
`endif
      end
`ifdef GHOST_FRIGHT_EN
      FRIGHT: begin
        if (overlap) begin
          stateNext = EATEN;
          eatenNext = 1'b1;
        end else if (powerPellet) begin
          frightCntNext = FRIGHT_LOAD;
        end else if (frightCnt == FRIGHT_CNT_W'(1)) begin
          stateNext = ACTIVE;
        end else begin
          frightCntNext = frightCnt - FRIGHT_CNT_W'(1);
          doMove        = 1'b1;
          step          = speed >> 1;
        end
      end
      EATEN: begin
        xNext       = xIni;
        yNext       = yIni;
        homeCntNext = '0;
        stateNext   = HOME;
      end
`endif
      default: begin
        xNext       = xIni;
        yNext       = yIni;
        homeCntNext = '0;
        stateNext   = HOME;
      end
    endcase
    if (doMove) begin
      case (direction)
        2'b00:   xNext = wrapMove(ghostX, step, 1'b1, FIELD_X);
        2'b01:   yNext = wrapMove(ghostY, step, 1'b1, FIELD_Y);
        2'b10:   xNext = wrapMove(ghostX, step, 1'b0, FIELD_X);
        default: yNext = wrapMove(ghostY, step, 1'b0, FIELD_Y);
      endcase
    end
  end

  // State, position and home counter registers.
  always_ff @(posedge move_clk or posedge reset) begin
    // NOTE: reset loads the home position straight from xIni/yIni, so they must be stable around reset.
    if (reset) begin
      stateCur <= HOME;
      ghostX   <= xIni;
      ghostY   <= yIni;
      homeCnt  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      stateCur <= stateNext;
      ghostX   <= xNext;
      ghostY   <= yNext;
      homeCnt  <= homeCntNext;
    end
  end

`ifdef GHOST_FRIGHT_EN
  // Frightened countdown and the registered one-tick eaten pulse.
  always_ff @(posedge move_clk or posedge reset) begin
    if (reset) begin
      frightCnt  <= '0;
      ghostEaten <= 1'b0;
    end else begin
      frightCnt  <= frightCntNext;
      ghostEaten <= eatenNext;
    end
  end

  assign frightened = (stateCur == FRIGHT);
`else
  logic unusedPellet;
  assign unusedPellet = powerPellet;
  assign frightened   = 1'b0;
  assign ghostEaten   = 1'b0;
`endif

endmodule

// File: tb/tb_ghost_mover.sv
// tb_ghost_mover: scoreboard bench for ghost_mover.
// Each tick the bench predicts position/state/flags, pushes the prediction,
// and pops it after the edge. Position is observed through ghostFill probes
// at the four box edges plus one pixel outside each.
module tb_ghost_mover;

  localparam int FIELD_W      = 380;
  localparam int FIELD_H      = 432;
  localparam int HG           = 10;
  localparam int HP           = 10;
  localparam int OFFSET_H     = 274;
  localparam int OFFSET_V     = 58;
  localparam int SPEED_W      = 5;
  localparam int HOME_TICKS   = 4;
  localparam int FRIGHT_TICKS = 5;

  localparam logic [1:0] HOME_S = 2'b00, ACTIVE_S = 2'b01, FRIGHT_S = 2'b10, EATEN_S = 2'b11;
  localparam logic [1:0] LEFT = 2'b00, UP = 2'b01, RIGHT = 2'b10, DOWN = 2'b11;

  logic moveClk = 1'b0;
  logic reset;
  logic [9:0] xIni, yIni, pacX, pacY, hCount, vCount;
  logic [1:0] direction;
  logic [SPEED_W-1:0] speed;
  logic powerPellet;
  logic ghostFill, touchPac, ghostEaten, frightened;
  logic [1:0] state;

  ghost_mover #(
    .FIELD_W(FIELD_W), .FIELD_H(FIELD_H), .SPRITE_W(2*HG+1), .PAC_W(2*HP+1),
    .OFFSET_H(OFFSET_H), .OFFSET_V(OFFSET_V), .SPEED_W(SPEED_W),
    .HOME_TICKS(HOME_TICKS), .FRIGHT_TICKS(FRIGHT_TICKS)
  ) dut (
    .move_clk(moveClk), .reset(reset), .xIni(xIni), .yIni(yIni),
    .direction(direction), .speed(speed), .pacX(pacX), .pacY(pacY),
    .powerPellet(powerPellet), .hCount(hCount), .vCount(vCount),
    .ghostFill(ghostFill), .touchPac(touchPac), .ghostEaten(ghostEaten),
    .frightened(frightened), .state(state)
  );

  always #20 moveClk = ~moveClk;

  typedef struct {
    string      tag;
    int         x;
    int         y;
    logic [1:0] st;
    logic       fr;
    logic       ge;
    logic       tp;
  } exp_t;

  exp_t sbQ[$];
  int expX, expY;
  int passCnt = 0;
  int checkCnt = 0;

  function automatic logic nearTo(input int a, input int b);
    return (((a > b) ? a - b : b - a) <= HG + HP);
  endfunction

  // Probe the four box edges and one pixel beyond each; a correct box reads 01100110.
  task automatic probeBox(input int x, input int y, output logic [7:0] pat);
    int cx, cy;
    cx = x + OFFSET_H;
    cy = y + OFFSET_V;
    vCount = 10'(cy);
    hCount = 10'(cx - HG - 1); #1 pat[7] = ghostFill;
    hCount = 10'(cx - HG);     #1 pat[6] = ghostFill;
    hCount = 10'(cx + HG);     #1 pat[5] = ghostFill;
    hCount = 10'(cx + HG + 1); #1 pat[4] = ghostFill;
    hCount = 10'(cx);
    vCount = 10'(cy - HG - 1); #1 pat[3] = ghostFill;
    vCount = 10'(cy - HG);     #1 pat[2] = ghostFill;
    vCount = 10'(cy + HG);     #1 pat[1] = ghostFill;
    vCount = 10'(cy + HG + 1); #1 pat[0] = ghostFill;
  endtask

  // Pop the oldest prediction and compare it with what the DUT shows now.
  task automatic scoreTick();
    exp_t e;
    logic [7:0] pat;
    if (sbQ.size() == 0) begin
      checkCnt++;
      $display("FAIL scoreboard: nothing queued to compare");
      return;
    end
    e = sbQ.pop_front();
    checkCnt++;
    if (state !== e.st) $display("FAIL %s state: got %b want %b", e.tag, state, e.st);
    else passCnt++;
    checkCnt++;
    if (frightened !== e.fr) $display("FAIL %s frightened: got %b want %b", e.tag, frightened, e.fr);
    else passCnt++;
    checkCnt++;
    if (ghostEaten !== e.ge) $display("FAIL %s ghostEaten: got %b want %b", e.tag, ghostEaten, e.ge);
    else passCnt++;
    checkCnt++;
    if (touchPac !== e.tp) $display("FAIL %s touchPac: got %b want %b", e.tag, touchPac, e.tp);
    else passCnt++;
    probeBox(e.x, e.y, pat);
    checkCnt++;
    if (pat !== 8'b0110_0110)
      $display("FAIL %s position: fill probe %b want 01100110 at x=%0d y=%0d", e.tag, pat, e.x, e.y);
    else passCnt++;
  endtask

  // Predict one edge: move the model by stepPx in the current direction, then check after the edge.
  task automatic cycle(input string tag, input logic [1:0] st, input int stepPx,
                       input logic fr, input logic ge);
    exp_t e;
    case (direction)
      LEFT:    expX = (expX - stepPx + FIELD_W) % FIELD_W;
      RIGHT:   expX = (expX + stepPx) % FIELD_W;
      UP:      expY = (expY - stepPx + FIELD_H) % FIELD_H;
      default: expY = (expY + stepPx) % FIELD_H;
    endcase
    e.tag = tag; e.x = expX; e.y = expY; e.st = st; e.fr = fr; e.ge = ge;
    e.tp = (st == ACTIVE_S) && nearTo(expX, int'(pacX)) && nearTo(expY, int'(pacY));
    sbQ.push_back(e);
    @(posedge moveClk);
    #1;
    scoreTick();
  endtask

  // Assert reset mid-cycle, check the asynchronous effect, release on a later falling edge.
  task automatic doReset(input int xi, input int yi);
    exp_t e;
    @(negedge moveClk);
    xIni = 10'(xi);
    yIni = 10'(yi);
    reset = 1'b1;
    expX = xi;
    expY = yi;
    e.tag = "reset"; e.x = xi; e.y = yi; e.st = HOME_S; e.fr = 1'b0; e.ge = 1'b0; e.tp = 1'b0;
    sbQ.push_back(e);
    #1;
    scoreTick();
    @(negedge moveClk);
    reset = 1'b0;
  endtask

  task automatic waitHome();
    for (int i = 0; i < HOME_TICKS - 1; i++) cycle("home", HOME_S, 0, 1'b0, 1'b0);
    cycle("release", ACTIVE_S, 0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    pacX = 10'd1000; pacY = 10'd1000;
    direction = RIGHT; speed = 5'd3;
    doReset(100, 200);
    waitHome();
    cycle("firstMove", ACTIVE_S, 3, 1'b0, 1'b0);
    cycle("secondMove", ACTIVE_S, 3, 1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    pacX = 10'd190; pacY = 10'd100;
    direction = LEFT; speed = 5'd5;
    doReset(2, 430);
    waitHome();
    cycle("wrapLeft", ACTIVE_S, 5, 1'b0, 1'b0);
    direction = RIGHT; speed = 5'd1;
    cycle("right1", ACTIVE_S, 1, 1'b0, 1'b0);
    speed = 5'd5;
    cycle("wrapRight", ACTIVE_S, 5, 1'b0, 1'b0);
    direction = DOWN; speed = 5'd4;
    cycle("wrapDown", ACTIVE_S, 4, 1'b0, 1'b0);
    direction = UP; speed = 5'd2;
    cycle("upToZero", ACTIVE_S, 2, 1'b0, 1'b0);
    speed = 5'd1;
    cycle("wrapUp", ACTIVE_S, 1, 1'b0, 1'b0);
    direction = LEFT; speed = 5'd3;
    cycle("leftToZero", ACTIVE_S, 3, 1'b0, 1'b0);
    speed = 5'd1;
    cycle("leftToMax", ACTIVE_S, 1, 1'b0, 1'b0);
    direction = RIGHT;
    cycle("rightExactField", ACTIVE_S, 1, 1'b0, 1'b0);
  endtask

  task automatic test_touch();
    int pxTab[7] = '{140, 120, 121, 80, 79, 100, 100};
    int pyTab[7] = '{200, 200, 200, 180, 180, 221, 220};
    logic tpTab[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    direction = RIGHT; speed = 5'd0;
    pacX = 10'd100; pacY = 10'd200;
    doReset(100, 200);
    waitHome();
    for (int i = 0; i < 7; i++) begin
      pacX = 10'(pxTab[i]);
      pacY = 10'(pyTab[i]);
      #1;
      checkCnt++;
      if (touchPac !== tpTab[i])
        $display("FAIL touchComb%0d: got %b want %b (pac %0d,%0d)", i, touchPac, tpTab[i], pxTab[i], pyTab[i]);
      else passCnt++;
      cycle("touchHold", ACTIVE_S, 0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_pellet();
    pacX = 10'd1000; pacY = 10'd1000;
    direction = RIGHT; speed = 5'd6;
    doReset(50, 50);
    waitHome();
    cycle("preMove", ACTIVE_S, 6, 1'b0, 1'b0);
    powerPellet = 1'b1;
`ifdef GHOST_FRIGHT_EN
    cycle("pelletEnter", FRIGHT_S, 6, 1'b1, 1'b0);
    powerPellet = 1'b0;
    cycle("fright1", FRIGHT_S, 3, 1'b1, 1'b0);
    cycle("fright2", FRIGHT_S, 3, 1'b1, 1'b0);
    powerPellet = 1'b1;
    cycle("frightReload", FRIGHT_S, 0, 1'b1, 1'b0);
    powerPellet = 1'b0;
    for (int i = 0; i < FRIGHT_TICKS - 1; i++) cycle("frightRun", FRIGHT_S, 3, 1'b1, 1'b0);
    cycle("frightExit", ACTIVE_S, 0, 1'b0, 1'b0);
    cycle("fullSpeed", ACTIVE_S, 6, 1'b0, 1'b0);
`else
    cycle("pelletIgnored", ACTIVE_S, 6, 1'b0, 1'b0);
    powerPellet = 1'b0;
    for (int i = 0; i < 3; i++) cycle("afterPellet", ACTIVE_S, 6, 1'b0, 1'b0);
`endif
  endtask

`ifdef GHOST_FRIGHT_EN
  task automatic test_eaten();
    pacX = 10'd1000; pacY = 10'd1000;
    direction = UP; speed = 5'd4;
    doReset(200, 100);
    waitHome();
    powerPellet = 1'b1;
    cycle("eatPellet", FRIGHT_S, 4, 1'b1, 1'b0);
    powerPellet = 1'b0;
    cycle("eatFright", FRIGHT_S, 2, 1'b1, 1'b0);
    pacX = 10'(expX); pacY = 10'(expY);
    powerPellet = 1'b1;
    cycle("eatenWins", EATEN_S, 0, 1'b0, 1'b1);
    powerPellet = 1'b0;
    pacX = 10'd1000; pacY = 10'd1000;
    expX = 200; expY = 100;
    cycle("eatenToHome", HOME_S, 0, 1'b0, 1'b0);
    waitHome();
    cycle("eatenMoves", ACTIVE_S, 4, 1'b0, 1'b0);
  endtask

  task automatic test_abort();
    pacX = 10'd1000; pacY = 10'd1000;
    direction = DOWN; speed = 5'd4;
    doReset(30, 30);
    waitHome();
    powerPellet = 1'b1;
    cycle("abortPellet", FRIGHT_S, 4, 1'b1, 1'b0);
    powerPellet = 1'b0;
    cycle("abortFright", FRIGHT_S, 2, 1'b1, 1'b0);
    doReset(60, 70);
    waitHome();
  endtask
`endif

  task automatic test_back_to_back();
    pacX = 10'd1000; pacY = 10'd1000;
    direction = UP; speed = 5'd2;
    doReset(100, 100);
    waitHome();
    cycle("b2bMove1", ACTIVE_S, 2, 1'b0, 1'b0);
    cycle("b2bMove2", ACTIVE_S, 2, 1'b0, 1'b0);
    doReset(300, 400);
    waitHome();
    direction = DOWN; speed = 5'd31;
    cycle("b2bFast", ACTIVE_S, 31, 1'b0, 1'b0);
    direction = LEFT;
    cycle("b2bTurn", ACTIVE_S, 31, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    xIni = '0; yIni = '0;
    direction = RIGHT; speed = '0;
    pacX = 10'd1000; pacY = 10'd1000;
    powerPellet = 1'b0;
    hCount = '0; vCount = '0;
    expX = 0; expY = 0;
    test_reset();
    test_wrap();
    test_touch();
    test_pellet();
`ifdef GHOST_FRIGHT_EN
    test_eaten();
    test_abort();
`endif
    test_back_to_back();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
